// File: rtl/fpu_pre_norm_align.sv
// -----------------------------------------------------------------------------
// fpu_pre_norm_align
//
// Pre-normalisation stage of the floating-point add/sub datapath. It sits
// between operand decode and the significand adder.
//
//   * Classifies both operands (NaN, Inf, zero, subnormal, normal).
//   * Resolves all special cases up front and reports them on exception_o
//     together with the final IEEE-754 result on exception_value_o.
//   * For ordinary operands, orders them by magnitude, selects the common
//     (larger) exponent, and right-aligns the smaller significand with
//     guard/round/sticky bits.
//
// Pipeline: two register stages (S1 classify/order, S2 align), latency of
// two cycles, one beat per cycle, skid-free valid/ready on both sides.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   in_valid_i/in_ready_o  upstream handshake
//   op_a_i, op_b_i         IEEE operands, W = 1+EXP_W+MAN_W bits
//   fpu_op_i               00 ADD, 01 SUB, 1x illegal
//   out_valid_o/out_ready_i downstream handshake
//   swap_o                 1 when B had the larger magnitude
//   sign_a_o, sign_b_o     effective signs of larger / smaller operand
//   exp_o                  common exponent (effective exponent of larger)
//   man_a_o                larger significand {hidden, man, 3'b000}
//   man_b_o                smaller significand aligned, LSB carries sticky
//   exception_o            special-case code (000 = ordinary operation)
//   exception_value_o      final result when exception_o != 000, else 0
// -----------------------------------------------------------------------------
module fpu_pre_norm_align #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [EXP_W+MAN_W:0]   op_a_i,
    input  logic [EXP_W+MAN_W:0]   op_b_i,
    input  logic [1:0]             fpu_op_i,

    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   swap_o,
    output logic                   sign_a_o,
    output logic                   sign_b_o,
    output logic [EXP_W-1:0]       exp_o,
    output logic [MAN_W+3:0]       man_a_o,
    output logic [MAN_W+3:0]       man_b_o,
    output logic [2:0]             exception_o,
    output logic [EXP_W+MAN_W:0]   exception_value_o
);

    localparam int W     = 1 + EXP_W + MAN_W;  // operand width
    localparam int SW    = MAN_W + 4;          // hidden + mantissa + G/R/S
    localparam int SIG_W = MAN_W + 1;          // hidden + mantissa

    typedef enum logic [2:0] {
        EXC_NONE        = 3'b000,
        EXC_PASS_A      = 3'b001,
        EXC_PASS_B      = 3'b010,
        EXC_INF         = 3'b011,
        EXC_NAN_INVALID = 3'b100,
        EXC_ILLEGAL_OP  = 3'b101,
        EXC_ZERO        = 3'b110
    } exc_e;

    localparam logic [EXP_W-1:0] EXP_ONES   = '1;
    localparam logic [EXP_W-1:0] EXP_ONE    = EXP_W'(1);
    localparam logic [MAN_W-1:0] QUIET_BIT  = {1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-1:0]     CANON_QNAN = {1'b0, EXP_ONES, QUIET_BIT};

    // -------------------------------------------------------------------------
    // Handshake: a stage advances when it is empty or its successor advances.
    // -------------------------------------------------------------------------
    logic v1_q, v2_q;
    logic adv1, adv2;

    assign adv2       = !v2_q || out_ready_i;
    assign adv1       = !v1_q || adv2;
    assign in_ready_o = adv1;

    // -------------------------------------------------------------------------
    // Stage 0 (combinational): field extraction and classification
    // -------------------------------------------------------------------------
    logic             sign_a, sign_b;      // sign_b is the effective sign
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W-1:0] man_a, man_b;

    assign sign_a = op_a_i[W-1];
    // Subtraction is folded into an addition with B's sign inverted, so every
    // later rule (Inf-Inf, signed zero, ordering) only ever sees addition.
    assign sign_b = op_b_i[W-1] ^ (fpu_op_i == 2'b01);
    assign exp_a  = op_a_i[W-2 -: EXP_W];
    assign exp_b  = op_b_i[W-2 -: EXP_W];
    assign man_a  = op_a_i[MAN_W-1:0];
    assign man_b  = op_b_i[MAN_W-1:0];

    logic a_exp_max, a_exp_zero, a_man_zero;
    logic b_exp_max, b_exp_zero, b_man_zero;
    logic a_nan, a_inf, a_zero;
    logic b_nan, b_inf, b_zero;

    assign a_exp_max  = (exp_a == EXP_ONES);
    assign a_exp_zero = (exp_a == '0);
    assign a_man_zero = (man_a == '0);
    assign b_exp_max  = (exp_b == EXP_ONES);
    assign b_exp_zero = (exp_b == '0);
    assign b_man_zero = (man_b == '0);

    assign a_nan  = a_exp_max  && !a_man_zero;
    assign a_inf  = a_exp_max  &&  a_man_zero;
    assign a_zero = a_exp_zero &&  a_man_zero;
    assign b_nan  = b_exp_max  && !b_man_zero;
    assign b_inf  = b_exp_max  &&  b_man_zero;
    assign b_zero = b_exp_zero &&  b_man_zero;

    // Subnormals share the scale of exponent 1 but have no hidden bit.
    logic [EXP_W-1:0] a_exp_eff, b_exp_eff;
    logic [SIG_W-1:0] sig_a, sig_b;
    logic             b_larger;

    assign a_exp_eff = a_exp_zero ? EXP_ONE : exp_a;
    assign b_exp_eff = b_exp_zero ? EXP_ONE : exp_b;
    assign sig_a     = {!a_exp_zero, man_a};
    assign sig_b     = {!b_exp_zero, man_b};

    // Ties keep A as the larger operand so equal magnitudes never swap.
    assign b_larger = (b_exp_eff > a_exp_eff) ||
                      ((b_exp_eff == a_exp_eff) && (sig_b > sig_a));

    exc_e             exc_d;
    logic [W-1:0]     exc_val_d;
    logic             swap_d, sign_l_d, sign_s_d;
    logic [EXP_W-1:0] exp_l_d, exp_s, diff_d;
    logic [SIG_W-1:0] sig_l_d, sig_s_d;

    // NOTE: every always_comb output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        exc_d     = EXC_NONE;
        exc_val_d = '0;
        swap_d    = 1'b0;
        sign_l_d  = 1'b0;
        sign_s_d  = 1'b0;
        exp_l_d   = '0;
        exp_s     = '0;
        sig_l_d   = '0;
        sig_s_d   = '0;

        // Priority chain: first matching rule wins.
        if (fpu_op_i[1]) begin
            exc_d = EXC_ILLEGAL_OP;
        end else if (a_nan) begin
            exc_d     = EXC_PASS_A;
            exc_val_d = {sign_a, exp_a, man_a | QUIET_BIT};
        end else if (b_nan) begin
            // A propagated NaN keeps its stored sign, not the SUB-flipped one.
            exc_d     = EXC_PASS_B;
            exc_val_d = {op_b_i[W-1], exp_b, man_b | QUIET_BIT};
        end else if (a_inf && b_inf && (sign_a != sign_b)) begin
            exc_d     = EXC_NAN_INVALID;
            exc_val_d = CANON_QNAN;
        end else if (a_inf) begin
            exc_d     = EXC_INF;
            exc_val_d = {sign_a, exp_a, man_a};
        end else if (b_inf) begin
            exc_d     = EXC_INF;
            exc_val_d = {sign_b, exp_b, man_b};
        end else if (a_zero && b_zero) begin
            // Round-to-nearest: only (-0) + (-0) yields -0.
            exc_d     = EXC_ZERO;
            exc_val_d = {sign_a && sign_b, {(W-1){1'b0}}};
        end else if (a_zero) begin
            exc_d     = EXC_PASS_B;
            exc_val_d = {sign_b, exp_b, man_b};
        end else if (b_zero) begin
            exc_d     = EXC_PASS_A;
            exc_val_d = op_a_i;
        end else if (b_larger) begin
            swap_d   = 1'b1;
            sign_l_d = sign_b;
            sign_s_d = sign_a;
            exp_l_d  = b_exp_eff;
            exp_s    = a_exp_eff;
            sig_l_d  = sig_b;
            sig_s_d  = sig_a;
        end else begin
            sign_l_d = sign_a;
            sign_s_d = sign_b;
            exp_l_d  = a_exp_eff;
            exp_s    = b_exp_eff;
            sig_l_d  = sig_a;
            sig_s_d  = sig_b;
        end
    end

    // Ordering guarantees exp_l_d >= exp_s, so this never wraps; on the
    // exception paths both are zero and the distance is zero.
    assign diff_d = exp_l_d - exp_s;

    // -------------------------------------------------------------------------
    // Stage 1 registers
    // -------------------------------------------------------------------------
    exc_e             exc1_q;
    logic [W-1:0]     exc_val1_q;
    logic             swap1_q, sign_l1_q, sign_s1_q;
    logic [EXP_W-1:0] exp_l1_q, diff1_q;
    logic [SIG_W-1:0] sig_l1_q, sig_s1_q;

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge value of its sources, independent of block order.
    // NOTE: data registers are reset along with the valid flags because the
    // outputs must read zero while reset is asserted, not just be ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q       <= 1'b0;
            exc1_q     <= EXC_NONE;
            exc_val1_q <= '0;
            swap1_q    <= 1'b0;
            sign_l1_q  <= 1'b0;
            sign_s1_q  <= 1'b0;
            exp_l1_q   <= '0;
            diff1_q    <= '0;
            sig_l1_q   <= '0;
            sig_s1_q   <= '0;
        end else begin
            if (adv1) begin
                v1_q <= in_valid_i;
            end
            if (adv1 && in_valid_i) begin
                exc1_q     <= exc_d;
                exc_val1_q <= exc_val_d;
                swap1_q    <= swap_d;
                sign_l1_q  <= sign_l_d;
                sign_s1_q  <= sign_s_d;
                exp_l1_q   <= exp_l_d;
                diff1_q    <= diff_d;
                sig_l1_q   <= sig_l_d;
                sig_s1_q   <= sig_s_d;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1 -> 2 (combinational): align the smaller significand
    // -------------------------------------------------------------------------
    logic [SW-1:0] ext_s;        // smaller significand with G/R/S appended
    logic [SW-1:0] shifted;
    logic [SW-1:0] lost_mask;    // bits that fall off the right end
    logic          sticky;
    logic [SW-1:0] man_b_d;

    assign ext_s = {sig_s1_q, 3'b000};

    always_comb begin
        shifted   = ext_s >> diff1_q;
        lost_mask = ~({SW{1'b1}} << diff1_q);
        sticky    = |(ext_s & lost_mask);
        if (32'(diff1_q) > 32'(SW - 1)) begin
            // Everything is shifted out; only the sticky bit survives.
            man_b_d = {{(SW-1){1'b0}}, |ext_s};
        end else begin
            man_b_d = {shifted[SW-1:1], shifted[0] | sticky};
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2 registers (drive the outputs directly)
    // -------------------------------------------------------------------------
    exc_e             exc2_q;
    logic [W-1:0]     exc_val2_q;
    logic             swap2_q, sign_l2_q, sign_s2_q;
    logic [EXP_W-1:0] exp2_q;
    logic [SW-1:0]    man_a2_q, man_b2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v2_q       <= 1'b0;
            exc2_q     <= EXC_NONE;
            exc_val2_q <= '0;
            swap2_q    <= 1'b0;
            sign_l2_q  <= 1'b0;
            sign_s2_q  <= 1'b0;
            exp2_q     <= '0;
            man_a2_q   <= '0;
            man_b2_q   <= '0;
        end else begin
            if (adv2) begin
                v2_q <= v1_q;
            end
            if (adv2 && v1_q) begin
                exc2_q     <= exc1_q;
                exc_val2_q <= exc_val1_q;
                swap2_q    <= swap1_q;
                sign_l2_q  <= sign_l1_q;
                sign_s2_q  <= sign_s1_q;
                exp2_q     <= exp_l1_q;
                man_a2_q   <= {sig_l1_q, 3'b000};
                man_b2_q   <= man_b_d;
            end
        end
    end

    assign out_valid_o       = v2_q;
    assign swap_o            = swap2_q;
    assign sign_a_o          = sign_l2_q;
    assign sign_b_o          = sign_s2_q;
    assign exp_o             = exp2_q;
    assign man_a_o           = man_a2_q;
    assign man_b_o           = man_b2_q;
    assign exception_o       = exc2_q;
    assign exception_value_o = exc_val2_q;

endmodule

// File: tb/tb_fpu_pre_norm_align.sv
// -----------------------------------------------------------------------------
// tb_fpu_pre_norm_align
//
// Self-checking bench for fpu_pre_norm_align (EXP_W=8, MAN_W=23).
// A table of operand pairs with hand-derived expected outputs is streamed
// through the pipeline; expected records enter a scoreboard queue when a beat
// is accepted and are compared when the beat leaves. Hand-written sequences
// cover back-pressure, capacity and asynchronous reset with beats in flight.
// -----------------------------------------------------------------------------
module tb_fpu_pre_norm_align;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 32;
    localparam int SW    = 27;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     op_a, op_b;
    logic [1:0]       fpu_op;
    logic             out_valid;
    logic             out_ready;
    logic             swap, sign_a, sign_b;
    logic [EXP_W-1:0] exp_out;
    logic [SW-1:0]    man_a, man_b;
    logic [2:0]       exc;
    logic [W-1:0]     exc_val;

    always #5 clk = ~clk;

    fpu_pre_norm_align #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .in_valid_i        (in_valid),
        .in_ready_o        (in_ready),
        .op_a_i            (op_a),
        .op_b_i            (op_b),
        .fpu_op_i          (fpu_op),
        .out_valid_o       (out_valid),
        .out_ready_i       (out_ready),
        .swap_o            (swap),
        .sign_a_o          (sign_a),
        .sign_b_o          (sign_b),
        .exp_o             (exp_out),
        .man_a_o           (man_a),
        .man_b_o           (man_b),
        .exception_o       (exc),
        .exception_value_o (exc_val)
    );

    typedef struct {
        logic             swap;
        logic             sa;
        logic             sb;
        logic [EXP_W-1:0] ex;
        logic [SW-1:0]    ma;
        logic [SW-1:0]    mb;
        logic [2:0]       exc;
        logic [W-1:0]     val;
    } exp_t;

    typedef struct {
        logic [1:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        exp_t       e;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    exp_t sb_q[$];

    function automatic vec_t mk(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sw, input logic sa, input logic sb,
                                input logic [EXP_W-1:0] ex, input logic [SW-1:0] ma,
                                input logic [SW-1:0] mb, input logic [2:0] ec,
                                input logic [W-1:0] val);
        vec_t v;
        v.op = op; v.a = a; v.b = b;
        v.e.swap = sw; v.e.sa = sa; v.e.sb = sb; v.e.ex = ex;
        v.e.ma = ma; v.e.mb = mb; v.e.exc = ec; v.e.val = val;
        return v;
    endfunction

    // Special-case record: all ordinary-path fields must be zero.
    function automatic vec_t mk_exc(input logic [1:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic [2:0] ec,
                                    input logic [W-1:0] val);
        return mk(op, a, b, 1'b0, 1'b0, 1'b0, '0, '0, '0, ec, val);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic compare_out(input exp_t e, input string tag);
        check({tag, " swap"},    64'(swap),    64'(e.swap));
        check({tag, " sign_a"},  64'(sign_a),  64'(e.sa));
        check({tag, " sign_b"},  64'(sign_b),  64'(e.sb));
        check({tag, " exp"},     64'(exp_out), 64'(e.ex));
        check({tag, " man_a"},   64'(man_a),   64'(e.ma));
        check({tag, " man_b"},   64'(man_b),   64'(e.mb));
        check({tag, " exc"},     64'(exc),     64'(e.exc));
        check({tag, " exc_val"}, 64'(exc_val), 64'(e.val));
    endtask

    task automatic drive(input vec_t v);
        fpu_op   = v.op;
        op_a     = v.a;
        op_b     = v.b;
        in_valid = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input vec_t v);
        int guard = 0;
        drive(v);
        forever begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(v.e);
                @(posedge clk); #1;
                in_valid = 1'b0;
                break;
            end
            @(posedge clk); #1;
            guard++;
            if (guard > 200) begin
                checks++; errors++;
                $display("FAIL send_timeout: in_ready stuck low, got 0 expected 1");
                in_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic collect(input int n, input bit rand_ready);
        int got  = 0;
        int idle = 0;
        exp_t e;
        while (got < n) begin
            @(posedge clk); #1;
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (out_valid && out_ready) begin
                idle = 0;
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_unexpected: got output, expected none");
                end else begin
                    e = sb_q.pop_front();
                    compare_out(e, $sformatf("vec%0d", got));
                end
                got++;
            end else begin
                idle++;
                if (idle > 200) begin
                    checks++; errors++;
                    $display("FAIL collect_timeout: got %0d beats expected %0d", got, n);
                    break;
                end
            end
        end
    endtask

    initial begin
        vec_t zero_v;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        fpu_op    = 2'b00;

        // Table: op, a, b, swap, sign_a, sign_b, exp, man_a, man_b, exc, value
        vecs.push_back(mk(2'b00, 32'h3F800000, 32'h3FC00000, 1, 0, 0, 8'h7F, 27'h6000000, 27'h4000000, 3'd0, 0));
        vecs.push_back(mk(2'b01, 32'h40400000, 32'h2B800000, 0, 0, 1, 8'h80, 27'h6000000, 27'h0000001, 3'd0, 0));
        vecs.push_back(mk_exc(2'b01, 32'h7F800000, 32'h7F800000, 3'd4, 32'h7FC00000));
        vecs.push_back(mk_exc(2'b00, 32'h7F800001, 32'h3F800000, 3'd1, 32'h7FC00001));
        vecs.push_back(mk_exc(2'b00, 32'h80000000, 32'h80000000, 3'd6, 32'h80000000));
        vecs.push_back(mk_exc(2'b10, 32'h3F800000, 32'h3F800000, 3'd5, 32'h00000000));
        vecs.push_back(mk(2'b00, 32'h00000001, 32'h00800000, 1, 0, 0, 8'h01, 27'h4000000, 27'h0000008, 3'd0, 0));
        vecs.push_back(mk_exc(2'b00, 32'h3F800000, 32'hFF800001, 3'd2, 32'hFFC00001));
        vecs.push_back(mk_exc(2'b01, 32'h3F800000, 32'h7FA00000, 3'd2, 32'h7FE00000));
        vecs.push_back(mk_exc(2'b01, 32'h3F800000, 32'h7F800000, 3'd3, 32'hFF800000));
        vecs.push_back(mk_exc(2'b00, 32'h7F800000, 32'h7F800000, 3'd3, 32'h7F800000));
        vecs.push_back(mk_exc(2'b01, 32'h00000000, 32'h40000000, 3'd2, 32'hC0000000));
        vecs.push_back(mk_exc(2'b00, 32'h40000000, 32'h80000000, 3'd1, 32'h40000000));
        vecs.push_back(mk_exc(2'b00, 32'h80000000, 32'h00000000, 3'd6, 32'h00000000));
        vecs.push_back(mk_exc(2'b11, 32'h7F800001, 32'h3F800000, 3'd5, 32'h00000000));
        vecs.push_back(mk(2'b01, 32'h3F800000, 32'h3F800000, 0, 0, 1, 8'h7F, 27'h4000000, 27'h4000000, 3'd0, 0));
        vecs.push_back(mk(2'b00, 32'h3F800000, 32'h3C000001, 0, 0, 0, 8'h7F, 27'h4000000, 27'h0080001, 3'd0, 0));
        vecs.push_back(mk(2'b00, 32'h3F800000, 32'h33000001, 0, 0, 0, 8'h7F, 27'h4000000, 27'h0000003, 3'd0, 0));
        vecs.push_back(mk(2'b00, 32'h3F800000, 32'h32800000, 0, 0, 0, 8'h7F, 27'h4000000, 27'h0000001, 3'd0, 0));
        vecs.push_back(mk(2'b00, 32'h3F800000, 32'h32000000, 0, 0, 0, 8'h7F, 27'h4000000, 27'h0000001, 3'd0, 0));
        vecs.push_back(mk(2'b00, 32'hC0000000, 32'h3F800000, 0, 1, 0, 8'h80, 27'h4000000, 27'h2000000, 3'd0, 0));
        vecs.push_back(mk(2'b00, 32'h00400000, 32'h01000000, 1, 0, 0, 8'h02, 27'h4000000, 27'h1000000, 3'd0, 0));
        vecs.push_back(mk(2'b01, 32'h3F800000, 32'h40000000, 1, 1, 0, 8'h80, 27'h4000000, 27'h2000000, 3'd0, 0));
        zero_v = mk_exc(2'b00, '0, '0, 3'd0, '0);

        // Reset state
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        compare_out(zero_v.e, "rst");
        #10 rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Table pass 1: free-flowing consumer; pass 2: random back-pressure.
        for (int pass = 0; pass < 2; pass++) begin
            @(posedge clk); #1;
            fork
                begin
                    for (int i = 0; i < vecs.size(); i++) send(vecs[i]);
                end
                collect(vecs.size(), pass == 1);
            join
            check("sb_empty", 64'(sb_q.size()), 64'd0);
        end

        // Back-pressure: capacity of two, outputs held, in-order drain.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(vecs[0]);
        @(negedge clk); check("bp_ready1", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        drive(vecs[1]);
        @(negedge clk); check("bp_ready2", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        drive(vecs[6]);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("bp_full_ready", 64'(in_ready), 64'd0);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            compare_out(vecs[0].e, "bp_hold");
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_ready", 64'(in_ready), 64'd1);
        check("bp_out1_valid", 64'(out_valid), 64'd1);
        compare_out(vecs[0].e, "bp_out1");
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_out2_valid", 64'(out_valid), 64'd1);
        compare_out(vecs[1].e, "bp_out2");
        @(posedge clk);
        @(negedge clk);
        check("bp_out3_valid", 64'(out_valid), 64'd1);
        compare_out(vecs[6].e, "bp_out3");
        @(posedge clk);
        @(negedge clk);
        check("bp_drained", 64'(out_valid), 64'd0);

        // Asynchronous reset with two beats in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(vecs[2]);
        @(posedge clk); #1;
        drive(vecs[3]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        compare_out(zero_v.e, "arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(vecs[1]);
        @(negedge clk); check("post_rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk); check("post_rst_lat1", 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("post_rst_lat2", 64'(out_valid), 64'd1);
        compare_out(vecs[1].e, "post_rst");
        @(posedge clk);
        @(negedge clk);
        check("post_rst_no_stale", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_pre_norm_align.md
Name: fpu_pre_norm_align

Overview:
- Parameterised, pipelined pre-normalisation stage for the FP add/sub datapath.
- Classifies both operands, including subnormals, and resolves special cases with IEEE-754 NaN/Inf/zero rules.
- For normal operations: orders operands by magnitude, picks the common exponent, and right-aligns the smaller significand with guard/round/sticky bits.
- Sits between the operand/decode stage and the significand adder; valid/ready on both sides.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa field width. Operand width W = 1+EXP_W+MAN_W. Significand output width SW = MAN_W+4 (hidden, mantissa, G, R, S).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  operands valid
- in_ready_o  out  1  block can accept
- op_a_i  in  W  operand A
- op_b_i  in  W  operand B
- fpu_op_i  in  2  00 ADD, 01 SUB, 10/11 illegal
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts
- swap_o  out  1  1 = operands exchanged (B was larger)
- sign_a_o  out  1  sign of larger operand (effective)
- sign_b_o  out  1  sign of smaller operand (effective)
- exp_o  out  EXP_W  common (larger) exponent
- man_a_o  out  SW  larger significand, unshifted, G/R/S = 0
- man_b_o  out  SW  aligned smaller significand
- exception_o  out  3  000 NONE, 001 PASS_A, 010 PASS_B, 011 INF, 100 NAN_INVALID, 101 ILLEGAL_OP, 110 ZERO
- exception_value_o  out  W  final result when exception_o != 000, else 0

Behaviour:
- Reset (async, rst_ni=0): both stage-valid flags and all outputs go to 0 immediately. In-flight operands are discarded. in_ready_o=1 after release.
- SUB: effective B sign = ~op_b_i sign before any classification.
- Classification:
  - exp=all-ones, man!=0 → NaN.
  - exp=all-ones, man=0 → Inf.
  - exp=0, man=0 → zero.
  - exp=0, man!=0 → subnormal: hidden bit 0, effective exponent 1.
  - Otherwise normal: hidden bit 1.
- Exception priority (first match wins):
  1. Illegal op → 101, value 0.
  2. A NaN → 001, value = A with quiet bit (mantissa MSB) forced to 1.
  3. B NaN → 010, value = B quietened, sign as input.
  4. A and B both Inf with opposite effective signs → 100, value = canonical qNaN (sign 0, exp all-ones, mantissa MSB only).
  5. Either Inf → 011, value = that infinity with its effective sign.
  6. Both zero → 110, value = -0 only if both effective signs are 1, else +0.
  7. A zero → 010, value = B with effective sign.
  8. B zero → 001, value = A.
- On any exception: swap_o, sign_*, exp_o and man_* are 0.
- Ordering: B is larger if exp_b > exp_a, or if exponents are equal and mantissa_b > mantissa_a. Then swap_o=1 and the A/B roles are exchanged; equal magnitude → no swap.
- Alignment:
  - d = exp_large - exp_small, using effective exponents.
  - man_b_o = {hidden, man, 3'b0} >> d. Bit 0 is the OR of bit 0 and every bit shifted out (sticky).
  - d > MAN_W+3 → man_b_o = 1 if the small significand is nonzero, else 0.
- Pipeline:
  - S1 registers classification, effective signs, swap, d and unshifted significands.
  - S2 registers the aligned result.
  - Latency: 2 cycles from accepted beat to out_valid_o.
  - Throughput: 1 beat/cycle.
- Handshake:
  - adv2 = !v2 | out_ready_i; adv1 = !v1 | adv2; in_ready_o = adv1 (combinational).
  - A transfer occurs on valid&ready.
  - Outputs hold stable while out_valid_o & !out_ready_i. Order is preserved; no beat is dropped or duplicated.
  - Capacity: 2 beats. With out_ready_i held low, in_ready_o falls after two accepts.
- Simultaneous accept at input and output when full: both occur the same cycle, so there is no bubble.

Test Plan:
- ADD 0x3F800000 + 0x3FC00000 (EXP_W=8, MAN_W=23) → 2 cycles later: swap_o=1, exp_o=0x7F, man_a_o=0x6000000, man_b_o=0x4000000, exception_o=000.
- SUB 0x40400000 - 0x2B800000 (d=41) → swap_o=0, sign_b_o=1, exp_o=0x80, man_a_o=0x6000000, man_b_o=0x0000001.
- Specials:
  - SUB 0x7F800000, 0x7F800000 → 100, value 0x7FC00000.
  - ADD 0x7F800001, 0x3F800000 → 001, value 0x7FC00001.
  - ADD 0x80000000 + 0x80000000 → 110, value 0x80000000.
  - fpu_op_i=10 → 101.
- Subnormal: ADD 0x00000001 + 0x00800000 → exp_o=0x01, swap_o=1, man_a_o=0x4000000, man_b_o=0x0000008.
- Back-pressure: 3 back-to-back beats with out_ready_i=0 for 4 cycles → in_ready_o=0 after 2 accepts; outputs stable. On release, beats emerge in order, one per cycle, and the third is then accepted.
- Reset with 2 beats in flight → out_valid_o=0 asynchronously and all outputs 0. After release, the next beat emerges with 2-cycle latency and no stale data.
